scroll_ctrl: RTL and testbench

SCROLL_CTRL -- requirements
Module: scroll_ctrl

---
 rtl/scroll_pkg.sv | 29 ++
 rtl/key_sync_edge.sv | 37 +++
 rtl/scroll_ctrl.sv | 133 +++++++++++++
 tb/tb_scroll_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling keypad display controller:
// FSM encoding, keypad command codes and the rotating window helper.
package scroll_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_SCROLL = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  localparam int unsigned DIGITS = 8;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_PAUSE = 4'hB;
  localparam logic [3:0] KEY_BKSP  = 4'hC;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  function automatic logic key_is_digit(input logic [3:0] code);
    return code <= 4'h9;
  endfunction

  // Four consecutive digits starting at ptr, wrapping 7->0, via a doubled-word shift.
  function automatic logic [15:0] window_at(input logic [31:0] num, input logic [2:0] ptr);
    logic [63:0] rot;
    rot = {num, num} << {ptr, 2'b00};
    return rot[63:48];
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for the keypad bus plus strobe rising-edge detection.
// The event is combinational from synchronized state so it acts on the 3rd edge.
module key_sync_edge (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] key_i,
  output logic       key_evt_o,
  output logic [3:0] key_code_o
);

  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic       prev_q;
  logic [1:0] vld_q;
  logic       armed_q;

  // armed_q needs a genuine low strobe after reset, so a key held through reset is not an event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= 1'b0;
      vld_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[4];
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~sync2_q[4]);
    end
  end

  assign key_evt_o  = sync2_q[4] & ~prev_q & armed_q;
  assign key_code_o = sync2_q[3:0];

endmodule

// File: rtl/scroll_ctrl.sv
// Keypad number entry (8 BCD digits) with a timed scrolling 4-digit window,
// pause/resume, backspace and clear.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int unsigned SCROLL_DIV = 33_333_333
) (
  input  logic        clk100mhz,
  input  logic        clr,
  input  logic [4:0]  key_in,
  output logic [31:0] number,
  output logic [15:0] window,
  output logic [3:0]  digit_cnt,
  output logic [1:0]  state,
  output logic        full
);

  localparam int unsigned TW = $clog2(SCROLL_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCROLL_DIV - 1);

  logic       key_evt;
  logic [3:0] key_code;

  key_sync_edge u_key (
    .clk_i      (clk100mhz),
    .rst_ni     (clr),
    .key_i      (key_in),
    .key_evt_o  (key_evt),
    .key_code_o (key_code)
  );

  state_t          state_q, state_d;
  logic [31:0]     number_q, number_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [15:0]     window_q, window_d;
  logic            full_q, full_d;
  logic            clear_evt, pause_evt, start_ok, cnt_full;

  assign cnt_full  = (cnt_q == 4'(DIGITS));
  assign clear_evt = key_evt && (key_code == KEY_CLEAR);
  assign pause_evt = key_evt && (key_code == KEY_PAUSE);
  assign start_ok  = key_evt && (key_code == KEY_START) && cnt_full;

  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) state_q <= ST_ENTRY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_evt) begin
      state_d = ST_ENTRY;
    end else begin
      case (state_q)
        ST_ENTRY:  if (start_ok)  state_d = ST_SCROLL;
        ST_SCROLL: if (pause_evt) state_d = ST_PAUSE;
        ST_PAUSE:  if (pause_evt) state_d = ST_SCROLL;
        default:                  state_d = ST_ENTRY;
      endcase
    end
  end

  // A pause event takes priority over the terminal count: pointer and counter both hold.
  always_comb begin
    number_d = number_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    tick_d   = tick_q;
    if (clear_evt) begin
      number_d = '0;
      cnt_d    = '0;
      ptr_d    = '0;
      tick_d   = '0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (key_evt) begin
            if (key_is_digit(key_code) && !cnt_full) begin
              number_d = {number_q[27:0], key_code};
              cnt_d    = cnt_q + 4'd1;
            end else if ((key_code == KEY_BKSP) && (cnt_q != '0)) begin
              number_d = {4'h0, number_q[31:4]};
              cnt_d    = cnt_q - 4'd1;
            end else if (start_ok) begin
              ptr_d  = '0;
              tick_d = '0;
            end
          end
        end
        ST_SCROLL: begin
          if (!pause_evt) begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              ptr_d  = ptr_q + 3'd1;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        default: ;
      endcase
    end
    full_d   = (cnt_d == 4'(DIGITS));
    window_d = (state_q == ST_ENTRY) ? number_q[15:0] : window_at(number_q, ptr_q);
  end

  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      number_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      tick_q   <= '0;
      window_q <= '0;
      full_q   <= 1'b0;
    end else begin
      number_q <= number_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      tick_q   <= tick_d;
      window_q <= window_d;
      full_q   <= full_d;
    end
  end

  assign number    = number_q;
  assign window    = window_q;
  assign digit_cnt = cnt_q;
  assign state     = state_q;
  assign full      = full_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Self-checking bench for scroll_ctrl with a transaction-level reference model
// (digit queue plus elapsed-tick arithmetic for the scroll position).
module tb_scroll_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [4:0]  key_in = '0;
  logic [31:0] number;
  logic [15:0] window;
  logic [3:0]  digit_cnt;
  logic [1:0]  state;
  logic        full;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model
  int q[$];
  int m_state = 0;
  int m_frozen = 0;
  int m_anchor = 0;
  bit m_run = 1'b0;

  scroll_ctrl #(.SCROLL_DIV(DIV)) dut (
    .clk100mhz (clk),
    .clr       (clr),
    .key_in    (key_in),
    .number    (number),
    .window    (window),
    .digit_cnt (digit_cnt),
    .state     (state),
    .full      (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  function automatic logic [31:0] m_number();
    logic [31:0] n = '0;
    foreach (q[i]) n = (n << 4) | 32'(q[i]);
    return n;
  endfunction

  function automatic int elapsed(int c);
    return m_run ? m_frozen + (c - m_anchor) : m_frozen;
  endfunction

  function automatic logic [15:0] exp_window(int c);
    logic [31:0] n = m_number();
    logic [15:0] w = '0;
    int p;
    if (m_state == 0) return n[15:0];
    p = (elapsed(c - 1) / DIV) % 8;
    for (int k = 0; k < 4; k++) w = (w << 4) | 16'((n >> (28 - 4 * ((p + k) % 8))) & 32'hF);
    return w;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_state = 0;
    m_run = 1'b0;
    m_frozen = 0;
    m_anchor = 0;
  endfunction

  function automatic void m_apply(int code, int eff);
    if (code == 15) begin
      m_reset();
    end else if (m_state == 0) begin
      if (code <= 9 && q.size() < 8) q.push_back(code);
      else if (code == 12 && q.size() > 0) void'(q.pop_back());
      else if (code == 10 && q.size() == 8) begin
        m_state = 1; m_frozen = 0; m_anchor = eff; m_run = 1'b1;
      end
    end else if (code == 11) begin
      if (m_state == 1) begin
        m_frozen = elapsed(eff - 1); m_run = 1'b0; m_state = 2;
      end else begin
        m_anchor = eff; m_run = 1'b1; m_state = 1;
      end
    end
  endfunction

  // align: 0 none, 1 effect coincides with terminal count, 2 effect while ptr==5
  task automatic press(input int code, input int align);
    int k;
    @(negedge clk) key_in = {1'b0, 4'(code)};
    @(negedge clk);
    if (align != 0) begin
      k = 0;
      while (k < 200 && ((align == 1) ? ((elapsed(cyc + 2) % DIV) != DIV - 1)
                                      : (((elapsed(cyc + 2) / DIV) % 8) != 5))) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (k >= 200) begin
        errors++;
        $display("FAIL align_wait: got timeout want alignment mode %0d", align);
      end
    end
    key_in[4] = 1'b1;
    @(negedge clk) key_in[4] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_apply(code, cyc);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    #1;
    checks++;
    if ({number, window, digit_cnt, state, full} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got num=%h win=%h cnt=%0d st=%0d full=%b want all zero",
               number, window, digit_cnt, state, full);
    end
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (6) @(negedge clk);
    m_reset();
  endtask

  task automatic test_entry_full();
    int seq[8] = '{4, 1, 2, 3, 0, 5, 6, 7};
    foreach (seq[i]) press(seq[i], 0);
    @(posedge clk); #1;
    checks++;
    if (number !== 32'h41230567 || number !== m_number()) begin
      errors++; $display("FAIL entry_number: got %h want %h", number, 32'h41230567);
    end
    checks++;
    if (digit_cnt !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL entry_full: got cnt=%0d full=%b want cnt=8 full=1", digit_cnt, full);
    end
    checks++;
    if (window !== 16'h0567) begin
      errors++; $display("FAIL entry_window: got %h want 0567", window);
    end
  endtask

  task automatic test_scroll();
    int es;
    press(9, 0);
    checks++;
    if (number !== 32'h41230567) begin
      errors++; $display("FAIL digit_when_full: got %h want 41230567", number);
    end
    press(10, 0);
    es = cyc;
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL start_state: got %0d want 1", state);
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (window !== exp_window(cyc)) begin
        errors++; $display("FAIL scroll_window c%0d: got %h want %h", cyc - es, window, exp_window(cyc));
      end
      if (k == 1 || k == 5 || k == 33) begin
        checks++;
        if (window !== ((k == 5) ? 16'h1230 : 16'h4123)) begin
          errors++; $display("FAIL scroll_fixed k%0d: got %h want %h", k, window,
                             (k == 5) ? 16'h1230 : 16'h4123);
        end
      end
    end
  endtask

  task automatic test_pause_terminal();
    logic [15:0] held;
    press(11, 1);
    checks++;
    if (state !== 2'd2) begin
      errors++; $display("FAIL pause_state: got %0d want 2", state);
    end
    held = exp_window(cyc + 1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      checks++;
      if (window !== held || state !== 2'd2) begin
        errors++; $display("FAIL pause_hold k%0d: got win=%h st=%0d want win=%h st=2", k, window, state, held);
      end
    end
    press(11, 0);
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL resume_state: got %0d want 1", state);
    end
    @(posedge clk); #1;
    checks++;
    if (window !== held) begin
      errors++; $display("FAIL resume_first: got %h want %h", window, held);
    end
    @(posedge clk); #1;
    checks++;
    if (window === held || window !== exp_window(cyc)) begin
      errors++; $display("FAIL resume_advance: got %h want %h", window, exp_window(cyc));
    end
  endtask

  task automatic test_clear();
    press(15, 2);
    checks++;
    if (state !== 2'd0 || number !== 32'h0 || digit_cnt !== 4'd0 || full !== 1'b0) begin
      errors++; $display("FAIL clear_regs: got st=%0d num=%h cnt=%0d full=%b want 0/0/0/0",
                         state, number, digit_cnt, full);
    end
    @(posedge clk); #1;
    checks++;
    if (window !== 16'h0) begin
      errors++; $display("FAIL clear_window: got %h want 0000", window);
    end
  endtask

  task automatic test_backspace();
    int seq[5] = '{1, 2, 3, 12, 10};
    foreach (seq[i]) press(seq[i], 0);
    checks++;
    if (number !== 32'h00000012 || digit_cnt !== 4'd2 || state !== 2'd0) begin
      errors++; $display("FAIL backspace: got num=%h cnt=%0d st=%0d want 00000012/2/0",
                         number, digit_cnt, state);
    end
    press(15, 0);
  endtask

  task automatic test_random();
    int code;
    for (int i = 0; i < 80; i++) begin
      code = $urandom_range(0, 15);
      if (code == 15 && $urandom_range(0, 3) != 0) code = $urandom_range(0, 9);
      press(code, 0);
      checks++;
      if (number !== m_number() || digit_cnt !== 4'(q.size()) || state !== 2'(m_state)
          || full !== (q.size() == 8)) begin
        errors++; $display("FAIL random_regs i%0d key%0h: got num=%h cnt=%0d st=%0d want num=%h cnt=%0d st=%0d",
                           i, code, number, digit_cnt, state, m_number(), q.size(), m_state);
      end
      @(posedge clk); #1;
      checks++;
      if (window !== exp_window(cyc)) begin
        errors++; $display("FAIL random_window i%0d: got %h want %h", i, window, exp_window(cyc));
      end
    end
    press(15, 0);
  endtask

  task automatic test_clr_midstrobe();
    press(1, 0);
    press(2, 0);
    press(3, 0);
    @(negedge clk) key_in = {1'b0, 4'h7};
    @(negedge clk) key_in[4] = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    m_reset();
    checks++;
    if (number !== 32'h0 || state !== 2'd0 || window !== 16'h0) begin
      errors++; $display("FAIL async_clr: got num=%h st=%0d win=%h want 0/0/0", number, state, window);
    end
    @(negedge clk) clr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (number !== 32'h0 || digit_cnt !== 4'd0) begin
      errors++; $display("FAIL held_strobe: got num=%h cnt=%0d want 0/0", number, digit_cnt);
    end
    @(negedge clk) key_in[4] = 1'b0;
    repeat (4) @(negedge clk);
    press(7, 0);
    checks++;
    if (number !== 32'h7 || digit_cnt !== 4'd1) begin
      errors++; $display("FAIL post_clr_key: got num=%h cnt=%0d want 00000007/1", number, digit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_entry_full();
    test_scroll();
    test_pause_terminal();
    test_clear();
    test_backspace();
    test_random();
    test_clr_midstrobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
